// File: rtl/decode_queue_pkg.sv
// Shared types, default sizes and the reserved-instruction template for the decode queue.
package decode_queue_pkg;

  localparam int FETCH_WIDTH_DEF = 2;
  localparam int ISSUE_WIDTH_DEF = 2;
  localparam int DEPTH_DEF       = 8;

  typedef logic [$clog2(DEPTH_DEF)-1:0] qptr_t;

  typedef enum logic [4:0] {
    OP_SLL, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_JR,
    OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW,
    OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_RESERVED
  } op_t;

  typedef struct packed {
    logic branch;
    logic jump;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic use_imm;
  } ctl_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    ctl_t        ctl;
    logic        ex_reserved;
  } decoded_instr_t;

  typedef struct packed {
    logic       bd;
    logic [4:0] exc_code;
    logic [7:0] ip;
  } cp0_cause_t;

  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  typedef struct packed {
    decoded_instr_t instr;
    logic [31:0]    pc;
    logic [31:0]    pcplus4;
    logic           in_delay_slot;
    cp0_cause_t     cause;
    cp0_status_t    status;
  } decode_data_t;

  // Anything the decoder does not recognise starts from this value.
  localparam decoded_instr_t RESERVED_INSTR = '{
    op: OP_RESERVED, rs: 5'd0, rt: 5'd0, rd: 5'd0, imm: 32'd0,
    ctl: '0, ex_reserved: 1'b1
  };

endpackage

// File: rtl/decode_queue_instr_decoder.sv
// Combinational single-instruction decoder; owns every opcode and funct table.
module instr_decoder
  import decode_queue_pkg::*;
(
  input  logic [31:0]    instr,
  output decoded_instr_t decoded
);

  logic [5:0] opcode;
  logic [5:0] funct;
  op_t        op;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    op = OP_RESERVED;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00:   op = OP_SLL;
          6'h08:   op = OP_JR;
          6'h21:   op = OP_ADDU;
          6'h23:   op = OP_SUBU;
          6'h24:   op = OP_AND;
          6'h25:   op = OP_OR;
          6'h26:   op = OP_XOR;
          default: op = OP_RESERVED;
        endcase
      end
      6'h02:   op = OP_J;
      6'h03:   op = OP_JAL;
      6'h04:   op = OP_BEQ;
      6'h05:   op = OP_BNE;
      6'h09:   op = OP_ADDIU;
      6'h0C:   op = OP_ANDI;
      6'h0D:   op = OP_ORI;
      6'h0F:   op = OP_LUI;
      6'h23:   op = OP_LW;
      6'h2B:   op = OP_SW;
      default: op = OP_RESERVED;
    endcase
  end

  // Control bits and immediate format follow from the resolved operation.
  always_comb begin
    decoded             = RESERVED_INSTR;
    decoded.op          = op;
    decoded.ex_reserved = (op == OP_RESERVED);
    decoded.rs          = instr[25:21];
    decoded.rt          = instr[20:16];
    decoded.rd          = instr[15:11];
    decoded.imm         = {{16{instr[15]}}, instr[15:0]};
    case (op)
      OP_SLL, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR:
        decoded.ctl.reg_write = 1'b1;
      OP_ADDIU: begin
        decoded.ctl.reg_write = 1'b1;
        decoded.ctl.use_imm   = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_LUI: begin
        decoded.ctl.reg_write = 1'b1;
        decoded.ctl.use_imm   = 1'b1;
        decoded.imm           = {16'd0, instr[15:0]};
      end
      OP_LW: begin
        decoded.ctl.mem_read  = 1'b1;
        decoded.ctl.reg_write = 1'b1;
        decoded.ctl.use_imm   = 1'b1;
      end
      OP_SW: begin
        decoded.ctl.mem_write = 1'b1;
        decoded.ctl.use_imm   = 1'b1;
      end
      OP_BEQ, OP_BNE:
        decoded.ctl.branch = 1'b1;
      OP_J: begin
        decoded.ctl.jump = 1'b1;
        decoded.imm      = {6'd0, instr[25:0]};
      end
      OP_JAL: begin
        decoded.ctl.jump      = 1'b1;
        decoded.ctl.reg_write = 1'b1;
        decoded.rd            = 5'd31;
        decoded.imm           = {6'd0, instr[25:0]};
      end
      OP_JR:
        decoded.ctl.jump = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Multi-wide decode stage feeding a circular queue of decoded instructions toward issue.
// Optional macro DECODE_QUEUE_BYPASS_EN: accepted slots reach the outputs in the same cycle when empty.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
  parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF
)(
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 flush,
  input  logic [FETCH_WIDTH-1:0]               in_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]         in_instr,
  input  logic [FETCH_WIDTH-1:0][31:0]         in_pc,
  input  cp0_cause_t                           in_cp0_cause,
  input  cp0_status_t                          in_cp0_status,
  output logic                                 in_ready,
  output logic [ISSUE_WIDTH-1:0]               out_valid,
  output decode_data_t [ISSUE_WIDTH-1:0]       out_data,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]     out_take
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  ptr_t           head;
  ptr_t           tail;
  cnt_t           count;
  logic           last_branch;
  decode_data_t   entries [DEPTH];

  decoded_instr_t         dec       [FETCH_WIDTH];
  decode_data_t           slot_data [FETCH_WIDTH];
  ptr_t                   wr_idx    [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] accepted;
  logic [FETCH_WIDTH-1:0] prev_cf;
  logic [FETCH_WIDTH-1:0] wr_en;
  cnt_t                   enq;
  cnt_t                   avail;
  cnt_t                   take_req;
  cnt_t                   take_eff;
  cnt_t                   skip;
  cnt_t                   q_take;
  cnt_t                   written;
  logic                   youngest_cf;
  logic                   bypass;
  logic                   valid_contig;

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_dec
    instr_decoder u_dec (
      .instr   (in_instr[g]),
      .decoded (dec[g])
    );
  end

  assign in_ready = (cnt_t'(DEPTH) - count) >= cnt_t'(FETCH_WIDTH);

`ifdef DECODE_QUEUE_BYPASS_EN
  assign bypass = (count == '0) && !flush;
`else
  assign bypass = 1'b0;
`endif

  // Slot 0's delay-slot flag comes from the youngest control transfer of the previous fetch.
  always_comb begin
    prev_cf[0] = last_branch;
    for (int i = 1; i < FETCH_WIDTH; i++)
      prev_cf[i] = dec[i-1].ctl.branch | dec[i-1].ctl.jump;
    enq         = '0;
    youngest_cf = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      accepted[i] = in_ready & in_valid[i];
      if (accepted[i]) begin
        enq         = enq + cnt_t'(1);
        youngest_cf = dec[i].ctl.branch | dec[i].ctl.jump;
      end
      slot_data[i] = '{instr: dec[i], pc: in_pc[i], pcplus4: in_pc[i] + 32'd4,
                       in_delay_slot: prev_cf[i], cause: in_cp0_cause,
                       status: in_cp0_status};
    end
  end

  always_comb begin
    valid_contig = 1'b1;
    for (int i = 1; i < FETCH_WIDTH; i++)
      if (in_valid[i] && !in_valid[i-1]) valid_contig = 1'b0;
  end

  // When bypassing, taken slots never touch storage and the rest pack down from tail.
  always_comb begin
    avail    = bypass ? enq : count;
    take_req = cnt_t'(out_take);
    take_eff = (take_req > avail) ? avail : take_req;
    skip     = bypass ? take_eff : '0;
    q_take   = bypass ? '0 : take_eff;
    written  = enq - skip;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_en[i]  = accepted[i] && !flush && (cnt_t'(i) >= skip);
      wr_idx[i] = tail + ptr_t'(i) - ptr_t'(skip);
    end
  end

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      out_valid[i] = count > cnt_t'(i);
      out_data[i]  = entries[head + ptr_t'(i)];
    end
`ifdef DECODE_QUEUE_BYPASS_EN
    if (bypass) begin
      out_valid = '0;
      for (int i = 0; i < ISSUE_WIDTH && i < FETCH_WIDTH; i++) begin
        out_valid[i] = accepted[i];
        out_data[i]  = slot_data[i];
      end
    end
`endif
  end

  // Flush discards everything by snapping head onto tail.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      last_branch <= 1'b0;
    end else if (flush) begin
      head        <= tail;
      count       <= '0;
      last_branch <= 1'b0;
    end else begin
      head  <= head + ptr_t'(q_take);
      tail  <= tail + ptr_t'(written);
      count <= count + written - q_take;
      if (enq != '0) last_branch <= youngest_cf;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (wr_en[i]) entries[wr_idx[i]] <= slot_data[i];
  end

  a_valid_contig: assert property (@(posedge clk) disable iff (!resetn) valid_contig);
  a_take_bound:   assert property (@(posedge clk) disable iff (!resetn) take_req <= avail);

endmodule

// File: tb/tb_decode_queue.sv
// Randomized self-checking bench for decode_queue against a queue-based reference model.
// Compile with DECODE_QUEUE_BYPASS_EN defined to exercise same-cycle bypass as well.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 8;
`ifdef DECODE_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   flush;
  logic [FW-1:0]          in_valid;
  logic [FW-1:0][31:0]    in_instr;
  logic [FW-1:0][31:0]    in_pc;
  cp0_cause_t             in_cp0_cause;
  cp0_status_t            in_cp0_status;
  logic                   in_ready;
  logic [IW-1:0]          out_valid;
  decode_data_t [IW-1:0]  out_data;
  logic [1:0]             out_take;

  decode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_cp0_cause  (in_cp0_cause),
    .in_cp0_status (in_cp0_status),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_take      (out_take)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    op_t         op;
    bit          branch;
    bit          jump;
    bit          delay;
    logic [23:0] snap;
  } exp_t;

  exp_t        model_q[$];
  bit          last_cf;
  int          checks;
  int          errors;
  logic [31:0] word  [FW];
  logic [31:0] pc_of [FW];
  logic [31:0] next_pc;

  localparam logic [31:0] W_ADDU = 32'h0022_1821;
  localparam logic [31:0] W_BEQ  = 32'h1022_0004;
  localparam logic [31:0] W_JAL  = 32'h0C00_0040;
  localparam logic [31:0] W_RSV  = 32'hFC00_0000;

  // Rows 0..16 are the known instructions; 17 and 18 are reserved encodings.
  localparam int N_KNOWN = 17;
  localparam logic [5:0] OPC [19] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                      6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B,
                                      6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h00};
  localparam logic [5:0] FN  [19] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h00, 6'h08,
                                      6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                      6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F};
  localparam op_t OPS [N_KNOWN] = '{OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_JR,
                                    OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW,
                                    OP_BEQ, OP_BNE, OP_J, OP_JAL};

  function automatic op_t refOp(input logic [31:0] w);
    for (int k = 0; k < N_KNOWN; k++)
      if (w[31:26] == OPC[k] && (OPC[k] != 6'h00 || w[5:0] == FN[k])) return OPS[k];
    return OP_RESERVED;
  endfunction

  function automatic logic [31:0] genWord();
    int          k;
    logic [31:0] w;
    k = $urandom_range(0, 18);
    w = $urandom;
    w[31:26] = OPC[k];
    if (OPC[k] == 6'h00) w[5:0] = FN[k];
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic setWords(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] pc0);
    word[0]  = w0;
    word[1]  = w1;
    pc_of[0] = pc0;
    pc_of[1] = pc0 + 32'd4;
  endtask

  task automatic randomWords();
    for (int i = 0; i < FW; i++) begin
      word[i]  = genWord();
      pc_of[i] = next_pc;
      next_pc  = next_pc + 32'd4;
    end
  endtask

  // One cycle: drive at the falling edge, check just after, update the model at the rising edge.
  task automatic applyStimulus(input int nv, input int take, input bit fl);
    exp_t          inc[$];
    exp_t          vis[$];
    exp_t          e;
    bit            ready;
    bit            bypass_now;
    logic [31:0]   r;
    logic [IW-1:0] exp_valid;
    r = $urandom;
    in_cp0_cause  = r[13:0];
    in_cp0_status = r[23:14];
    for (int i = 0; i < FW; i++) begin
      in_valid[i] = (i < nv);
      in_instr[i] = word[i];
      in_pc[i]    = pc_of[i];
    end
    out_take = take[1:0];
    flush    = fl;
    #1;
    ready = (DEPTH - model_q.size()) >= FW;
    if (ready) begin
      for (int i = 0; i < nv; i++) begin
        e.pc     = pc_of[i];
        e.op     = refOp(word[i]);
        e.branch = e.op inside {OP_BEQ, OP_BNE};
        e.jump   = e.op inside {OP_J, OP_JAL, OP_JR};
        e.delay  = (i == 0) ? last_cf : (inc[i-1].branch || inc[i-1].jump);
        e.snap   = {in_cp0_cause, in_cp0_status};
        inc.push_back(e);
      end
    end
    bypass_now = BYPASS && (model_q.size() == 0) && !fl;
    if (bypass_now) vis = inc;
    else vis = model_q;
    for (int i = 0; i < IW; i++) exp_valid[i] = (i < vis.size());
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, ready});
    checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
    for (int i = 0; i < IW; i++) begin
      if (i < vis.size()) begin
        checkOutput($sformatf("pc%0d", i), out_data[i].pc, vis[i].pc);
        checkOutput($sformatf("pcplus4_%0d", i), out_data[i].pcplus4, vis[i].pc + 32'd4);
        checkOutput($sformatf("op%0d", i), 32'(out_data[i].instr.op), 32'(vis[i].op));
        checkOutput($sformatf("flags%0d", i),
                    {28'd0, out_data[i].instr.ex_reserved, out_data[i].instr.ctl.branch,
                     out_data[i].instr.ctl.jump, out_data[i].in_delay_slot},
                    {28'd0, vis[i].op == OP_RESERVED, vis[i].branch, vis[i].jump, vis[i].delay});
        checkOutput($sformatf("cp0_%0d", i), {8'd0, out_data[i].cause, out_data[i].status},
                    {8'd0, vis[i].snap});
      end
    end
    @(posedge clk);
    if (fl) begin
      model_q.delete();
      last_cf = 1'b0;
    end else begin
      if (inc.size() > 0) last_cf = inc[$].branch || inc[$].jump;
      for (int k = 0; k < take; k++) begin
        if (bypass_now) void'(inc.pop_front());
        else void'(model_q.pop_front());
      end
      foreach (inc[k]) model_q.push_back(inc[k]);
    end
    @(negedge clk);
  endtask

  task automatic midReset();
    resetn   = 1'b0;
    flush    = 1'b0;
    in_valid = '0;
    out_take = '0;
    #1;
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    model_q.delete();
    last_cf = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int nv;
    int take;
    int vis_n;
    bit fl;
    checks        = 0;
    errors        = 0;
    last_cf       = 1'b0;
    next_pc       = 32'h0000_1000;
    resetn        = 1'b0;
    flush         = 1'b0;
    in_valid      = '0;
    in_instr      = '0;
    in_pc         = '0;
    in_cp0_cause  = '0;
    in_cp0_status = '0;
    out_take      = '0;
    setWords(W_ADDU, W_ADDU, 32'h100);

    @(negedge clk);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    resetn = 1'b1;

    // Two ADDUs become visible one cycle after being accepted.
    applyStimulus(2, 0, 1'b0);
    checkOutput("t1_valid", 32'(out_valid), 32'd3);
    checkOutput("t1_pcplus4_0", out_data[0].pcplus4, 32'h104);
    checkOutput("t1_pcplus4_1", out_data[1].pcplus4, 32'h108);
    applyStimulus(0, 2, 1'b0);

    // Fill to capacity, then sit at seven entries.
    for (int c = 0; c < 4; c++) begin
      randomWords();
      applyStimulus(2, 0, 1'b0);
    end
    checkOutput("full_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("full_valid", 32'(out_valid), 32'd3);
    randomWords();
    applyStimulus(2, 1, 1'b0);
    checkOutput("c7_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(0, 2, 1'b0);
    applyStimulus(0, 1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      randomWords();
      applyStimulus(2, 2, 1'b0);
    end
    for (int c = 0; c < 2; c++) applyStimulus(0, 2, 1'b0);

    // Delay slots across and within fetch groups.
    setWords(W_ADDU, W_BEQ, 32'h200);
    applyStimulus(2, 0, 1'b0);
    setWords(W_ADDU, W_ADDU, 32'h208);
    applyStimulus(1, 0, 1'b0);
    setWords(W_JAL, W_ADDU, 32'h20C);
    applyStimulus(2, 0, 1'b0);
    applyStimulus(0, 2, 1'b0);
    checkOutput("ds_after_beq", {31'd0, out_data[0].in_delay_slot}, 32'd1);
    checkOutput("ds_jal_slot0", {31'd0, out_data[1].in_delay_slot}, 32'd0);
    applyStimulus(0, 2, 1'b0);
    checkOutput("ds_after_jal", {31'd0, out_data[0].in_delay_slot}, 32'd1);
    applyStimulus(0, 1, 1'b0);

    // Reserved encoding.
    setWords(W_RSV, W_ADDU, 32'h300);
    applyStimulus(1, 0, 1'b0);
    checkOutput("rsv_op", 32'(out_data[0].instr.op), 32'(OP_RESERVED));
    checkOutput("rsv_flag", {31'd0, out_data[0].instr.ex_reserved}, 32'd1);
    applyStimulus(0, 1, 1'b0);

    // Flush wins over a simultaneous enqueue and dequeue at five entries.
    setWords(W_ADDU, W_ADDU, 32'h400);
    applyStimulus(2, 0, 1'b0);
    setWords(W_ADDU, W_ADDU, 32'h408);
    applyStimulus(2, 0, 1'b0);
    setWords(W_BEQ, W_ADDU, 32'h410);
    applyStimulus(1, 0, 1'b0);
    setWords(W_ADDU, W_BEQ, 32'h414);
    applyStimulus(2, 2, 1'b1);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_ready", {31'd0, in_ready}, 32'd1);
    setWords(W_ADDU, W_ADDU, 32'h500);
    applyStimulus(1, 0, 1'b0);
    checkOutput("flush_last_branch", {31'd0, out_data[0].in_delay_slot}, 32'd0);
    applyStimulus(0, 1, 1'b0);

`ifdef DECODE_QUEUE_BYPASS_EN
    // Empty queue: both slots consumed straight through, nothing stored.
    setWords(W_ADDU, W_ADDU, 32'h600);
    applyStimulus(2, 2, 1'b0);
    checkOutput("byp_after_valid", 32'(out_valid), 32'd0);
    checkOutput("byp_after_ready", {31'd0, in_ready}, 32'd1);
`endif

    // Random traffic with occasional flushes and one mid-run reset.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) midReset();
      randomWords();
      nv = $urandom_range(0, FW);
      fl = ($urandom_range(0, 19) == 0);
      if (BYPASS && model_q.size() == 0 && !fl) vis_n = nv;
      else vis_n = model_q.size();
      if (vis_n > IW) vis_n = IW;
      take = $urandom_range(0, vis_n);
      applyStimulus(nv, take, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
